// File: rtl/spi_slave_adc_16bit.sv
// spi_slave_adc_16bit
//   SPI mode-0 responder (CPOL=0, CPHA=0) for the ADC end of a 16-bit link.
//   sclk/cs_n/mosi are oversampled in the clk domain. A one-deep holding
//   register (valid/ready) supplies the word shifted out MSB first on miso,
//   and the 16 bits captured from mosi are presented with a one-cycle strobe.
//
//   Optional build macro: SPI_SLAVE_ECHO_EN -- a frame that starts with the
//   holding register empty transmits the last rx_data instead of zeros.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sclk, cs_n, mosi    SPI from master (asynchronous to clk)
//   miso, miso_oe       slave data out and pad enable (miso_oe = busy)
//   tx_data/valid/ready holding-register load handshake
//   rx_data, rx_valid   last complete received word and its update strobe
//   underrun            strobe: frame started with holding register empty
//   frame_err           strobe: cs_n released after 1..DATA_W-1 sclk rises
//   busy                frame active
module spi_slave_adc_16bit #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   armed_q, armed_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_tx_q, shift_tx_d;
  logic [DATA_W-2:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [DATA_W-1:0] empty_word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

`ifdef SPI_SLAVE_ECHO_EN
  assign empty_word = rx_data_q;
`else
  assign empty_word = '0;
`endif

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    // fill_q marks when the synchronizer output holds a real pin sample
    // rather than its reset value; the reset value of cs_n (high) must not
    // arm the block, or a reset released mid-frame would start a partial frame.
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_tx_d  = shift_tx_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          // A load in this same cycle cannot be taken when holding is full,
          // and when holding is empty the new word stays for the next frame.
          if (hold_full_q) begin
            shift_tx_d  = hold_q;
            hold_full_d = 1'b0;
          end else begin
            shift_tx_d = empty_word;
            underrun_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          shift_tx_d = shift_tx_q << 1;
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shift_tx_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_tx_q  <= shift_tx_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign miso_oe   = busy;
  assign miso      = (state_q == ST_SHIFT) & shift_tx_q[DATA_W-1];
  assign tx_ready  = ~hold_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_adc_16bit.sv
// Self-checking bench for spi_slave_adc_16bit: directed and randomized SPI
// frames checked against a frame-level model of the holding register,
// transmitted word and received word.
module tb_spi_slave_adc_16bit;

  localparam int DW = 16;
  localparam int H  = 8;  // sclk half-period in clk cycles

`ifdef SPI_SLAVE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, sclk, cs_n, mosi, tx_valid;
  logic [DW-1:0] tx_data;
  logic          miso, miso_oe, tx_ready, rx_valid, underrun, frame_err, busy;
  logic [DW-1:0] rx_data;

  always #5 clk = ~clk;

  spi_slave_adc_16bit #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .underrun(underrun), .frame_err(frame_err), .busy(busy)
  );

  int checks = 0;
  int fails  = 0;
  int n_rxv = 0, n_ferr = 0, n_und = 0;

  // frame-level model
  bit            m_full = 1'b0;
  logic [DW-1:0] m_hold = '0;
  logic [DW-1:0] m_last = '0;

  bit pend = 1'b0, pend_hit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clk cycle; also releases a pending tx_valid once it has been accepted
  task automatic tick();
    @(negedge clk);
    if (pend) begin
      if (pend_hit) begin
        tx_valid = 1'b0;
        pend     = 1'b0;
        pend_hit = 1'b0;
      end else if (tx_ready) begin
        pend_hit = 1'b1;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic mbit(input logic [DW-1:0] w, input int i);
    if (i < DW) return w[DW-1-i];
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic load(input logic [DW-1:0] w);
    chk("tx_ready_before_load", tx_ready, {31'd0, !m_full});
    tx_valid = 1'b1;
    tx_data  = w;
    tick();
    tx_valid = 1'b0;
    tx_data  = DW'($urandom);
    if (!m_full) begin
      m_full = 1'b1;
      m_hold = w;
    end
  endtask

  task automatic do_frame(input logic [DW-1:0] mw, input int npulse,
                          input bit load_at_fall, input logic [DW-1:0] lw,
                          output logic [DW-1:0] got);
    logic [DW-1:0] sent;
    logic          eb;
    bit            exp_und;
    int            r0, f0, u0;
    r0 = n_rxv; f0 = n_ferr; u0 = n_und;
    got = '0;
    if (m_full) begin
      sent = m_hold; m_full = 1'b0; exp_und = 1'b0;
    end else begin
      sent = ECHO ? m_last : '0; exp_und = 1'b1;
    end
    cs_n = 1'b0;
    mosi = mbit(mw, 0);
    if (load_at_fall) begin
      tx_valid = 1'b1; tx_data = lw; pend = 1'b1; pend_hit = 1'b0;
    end
    ticks(H);
    for (int i = 0; i < npulse; i++) begin
      eb = (i < DW) ? sent[DW-1-i] : 1'b0;
      chk("miso_bit", miso, eb);
      chk("busy_in_frame", busy, 1);
      if (i < DW) got[DW-1-i] = miso;
      sclk = 1'b1;
      ticks(H);
      sclk = 1'b0;
      mosi = mbit(mw, i + 1);
      ticks(H);
    end
    cs_n = 1'b1;
    ticks(2 * H);
    if (load_at_fall) begin
      chk("load_at_fall_accepted", pend, 0);
      tx_valid = 1'b0; pend = 1'b0; pend_hit = 1'b0;
      m_full = 1'b1; m_hold = lw;
    end
    if (npulse >= DW) m_last = mw;
    chk("rx_valid_count", n_rxv - r0, (npulse >= DW) ? 1 : 0);
    chk("frame_err_count", n_ferr - f0, (npulse >= 1 && npulse < DW) ? 1 : 0);
    chk("underrun_count", n_und - u0, exp_und ? 1 : 0);
    chk("rx_data", rx_data, m_last);
    chk("busy_after_frame", busy, 0);
    chk("tx_ready_after_frame", tx_ready, {31'd0, !m_full});
  endtask

  initial begin
    logic [DW-1:0] got;
    int            r0, f0, u0;
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    fork
      begin : monitor
        bit prev_rxv = 1'b0;
        forever begin
          @(negedge clk);
          if (rx_valid === 1'b1) n_rxv++;
          if (frame_err === 1'b1) n_ferr++;
          if (underrun === 1'b1) n_und++;
          if (rst_n) begin
            chk("miso_oe_eq_busy", miso_oe, busy);
            if (!busy) chk("miso_idle_zero", miso, 0);
            if (prev_rxv) chk("rx_valid_one_cycle", rx_valid, 0);
          end
          prev_rxv = rx_valid;
        end
      end
      begin : watchdog
        repeat (200000) @(negedge clk);
        chk("watchdog_timeout", 1, 0);
      end
      begin : main
        ticks(3);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        ticks(10);

        // basic frame
        load(16'hA5C3);
        do_frame(16'h1234, 16, 1'b0, '0, got);
        chk("t1_miso_word", got, 16'hA5C3);
        chk("t1_rx_data", rx_data, 16'h1234);

        // no load -> underrun
        do_frame(16'h5A5A, 16, 1'b0, '0, got);
        chk("t2_miso_word", got, ECHO ? 16'h1234 : 16'h0000);

        // short frame, then full frame
        do_frame(16'hBEEF, 7, 1'b0, '0, got);
        chk("t3_rx_data_held", rx_data, 16'h5A5A);
        do_frame(16'h00FF, 16, 1'b0, '0, got);
        chk("t3_rx_data", rx_data, 16'h00FF);

        // over-long frame
        load(16'hFFFF);
        do_frame(16'hC0DE, 18, 1'b0, '0, got);
        chk("t4_miso_word", got, 16'hFFFF);

        // load coinciding with frame start, refused third word
        load(16'h1111);
        do_frame(16'h0F0F, 16, 1'b1, 16'h2222, got);
        chk("t5_first_word", got, 16'h1111);
        chk("t5_ready_full", tx_ready, 0);
        load(16'h3333);
        do_frame(16'hF0F0, 16, 1'b0, '0, got);
        chk("t5_second_word", got, 16'h2222);

        // reset mid-frame
        load(16'h7E57);
        cs_n = 1'b0; mosi = 1'b1;
        ticks(H);
        for (int i = 0; i < 5; i++) begin
          sclk = 1'b1; ticks(H); sclk = 1'b0; ticks(H);
        end
        rst_n = 1'b0;
        ticks(3);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        m_full = 1'b0; m_last = '0;
        r0 = n_rxv; f0 = n_ferr; u0 = n_und;
        for (int i = 0; i < 11; i++) begin
          chk("post_rst_miso", miso, 0);
          chk("post_rst_busy", busy, 0);
          sclk = 1'b1; ticks(H); sclk = 1'b0; mosi = ~mosi; ticks(H);
        end
        cs_n = 1'b1;
        ticks(2 * H);
        chk("post_rst_rx_valid", n_rxv - r0, 0);
        chk("post_rst_frame_err", n_ferr - f0, 0);
        chk("post_rst_underrun", n_und - u0, 0);
        load(16'h9C3A);
        do_frame(16'h4B1D, 16, 1'b0, '0, got);
        chk("t6_miso_word", got, 16'h9C3A);
        chk("t6_rx_data", rx_data, 16'h4B1D);

        // randomized frames
        for (int k = 0; k < 24; k++) begin
          int sel, np;
          if ($urandom_range(0, 1) == 1) load(DW'($urandom));
          sel = $urandom_range(0, 3);
          if (sel < 2)       np = DW;
          else if (sel == 2) np = $urandom_range(0, DW - 1);
          else               np = $urandom_range(DW + 1, DW + 3);
          do_frame(DW'($urandom), np, 1'b0, '0, got);
        end
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
